// File: rtl/adc_shift_accumulator.sv
// Bit-serial MAC post-processor: removes the ADC mid-code offset from each column's
// per-plane code and shift-adds the planes (MSB first) into a saturating signed accumulator.
module adc_shift_accumulator #(
    parameter int numCols    = 1,
    parameter int numAdcBits = 4,
    parameter int numCfgBits = 8,
    parameter int accBits    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [numCfgBits-1:0]         n_input_bits_cfg,
    input  logic                          signed_cfg,
    input  logic                          start_i,
    input  logic                          adc_valid_i,
    input  logic [numCols*numAdcBits-1:0] adc_out_i,
    output logic                          acc_valid_o,
    input  logic                          acc_ready_i,
    output logic [numCols*accBits-1:0]    acc_data_o,
    output logic                          busy_o,
    output logic                          sat_o,
    output logic                          err_o
);

    // Two guard bits hold 2*acc +/- sample without overflow before clamping.
    localparam int EXT_W = accBits + 2;
    localparam logic signed [EXT_W-1:0] ACC_MAX = (EXT_W'(1) <<< (accBits - 1)) - EXT_W'(1);
    localparam logic signed [EXT_W-1:0] ACC_MIN = -ACC_MAX - EXT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [numCfgBits-1:0]   cnt_q, cnt_d;
    logic [numCfgBits-1:0]   nplanes_q, nplanes_d;
    logic                    signed_q, signed_d;
    logic                    sat_q, sat_d;
    logic                    err_q, err_d;
    logic signed [accBits-1:0] acc_q [numCols];
    logic signed [accBits-1:0] acc_d [numCols];

    logic                    do_clear;
    logic                    do_step;
    logic                    do_drop;
    logic                    neg_plane;
    logic signed [EXT_W-1:0] sum_w [numCols];
    logic signed [accBits-1:0] step_val [numCols];
    logic [numCols-1:0]      step_clamp;

    // Offset-binary ADC code to two's complement: flipping the MSB subtracts 2^(numAdcBits-1).
    function automatic logic signed [EXT_W-1:0] adc_to_signed(input logic [numAdcBits-1:0] code);
        logic [numAdcBits-1:0] t;
        t = code;
        t[numAdcBits-1] = ~code[numAdcBits-1];
        return EXT_W'(signed'(t));
    endfunction

    function automatic logic is_clamped(input logic signed [EXT_W-1:0] v);
        return (v > ACC_MAX) || (v < ACC_MIN);
    endfunction

    function automatic logic signed [accBits-1:0] sat_acc(input logic signed [EXT_W-1:0] v);
        if (v > ACC_MAX) begin
            return ACC_MAX[accBits-1:0];
        end else if (v < ACC_MIN) begin
            return ACC_MIN[accBits-1:0];
        end
        return v[accBits-1:0];
    endfunction

    // The first plane of a two's-complement input carries negative weight.
    assign neg_plane = signed_q && (cnt_q == '0);

    always_comb begin
        for (int c = 0; c < numCols; c++) begin
            if (neg_plane) begin
                sum_w[c] = (EXT_W'(acc_q[c]) <<< 1)
                           - adc_to_signed(adc_out_i[c*numAdcBits +: numAdcBits]);
            end else begin
                sum_w[c] = (EXT_W'(acc_q[c]) <<< 1)
                           + adc_to_signed(adc_out_i[c*numAdcBits +: numAdcBits]);
            end
            step_val[c]   = sat_acc(sum_w[c]);
            step_clamp[c] = is_clamped(sum_w[c]);
        end
    end

    always_comb begin
        state_d  = state_q;
        do_clear = 1'b0;
        do_step  = 1'b0;
        do_drop  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    do_clear = 1'b1;
                    state_d  = ACC;
                end else if (adc_valid_i) begin
                    do_drop = 1'b1;
                end
            end
            ACC: begin
                // A sample coinciding with a restart is discarded, not flagged.
                if (start_i) begin
                    do_clear = 1'b1;
                end else if (adc_valid_i) begin
                    do_step = 1'b1;
                    if (cnt_q == nplanes_q - 1'b1) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (acc_ready_i && start_i) begin
                    do_clear = 1'b1;
                    state_d  = ACC;
                end else begin
                    do_drop = adc_valid_i;
                    if (acc_ready_i) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        nplanes_d = nplanes_q;
        signed_d  = signed_q;
        sat_d     = sat_q;
        err_d     = err_q;
        for (int c = 0; c < numCols; c++) begin
            acc_d[c] = acc_q[c];
        end
        if (do_clear) begin
            cnt_d     = '0;
            nplanes_d = (n_input_bits_cfg == '0) ? numCfgBits'(1) : n_input_bits_cfg;
            signed_d  = signed_cfg;
            sat_d     = 1'b0;
            err_d     = 1'b0;
            for (int c = 0; c < numCols; c++) begin
                acc_d[c] = '0;
            end
        end else begin
            if (do_step) begin
                cnt_d = cnt_q + 1'b1;
                sat_d = sat_q | (|step_clamp);
                for (int c = 0; c < numCols; c++) begin
                    acc_d[c] = step_val[c];
                end
            end
            if (do_drop) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            nplanes_q <= '0;
            signed_q  <= 1'b0;
            sat_q     <= 1'b0;
            err_q     <= 1'b0;
            for (int c = 0; c < numCols; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            nplanes_q <= nplanes_d;
            signed_q  <= signed_d;
            sat_q     <= sat_d;
            err_q     <= err_d;
            for (int c = 0; c < numCols; c++) begin
                acc_q[c] <= acc_d[c];
            end
        end
    end

    // Accumulators are frozen in HOLD, so they double as the registered result.
    for (genvar g = 0; g < numCols; g++) begin : g_out
        assign acc_data_o[g*accBits +: accBits] = acc_q[g];
    end

    assign acc_valid_o = (state_q == HOLD);
    assign busy_o      = (state_q != IDLE);
    assign sat_o       = sat_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_adc_shift_accumulator.sv
// Randomised and directed bench for adc_shift_accumulator (2 columns, 8-bit accumulators)
// checked every cycle against a plane-by-plane arithmetic model.
module tb_adc_shift_accumulator;

    localparam int NC   = 2;
    localparam int AB   = 4;
    localparam int CB   = 8;
    localparam int ACCB = 8;
    localparam int HI   = 127;
    localparam int LO   = -128;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [CB-1:0]        n_input_bits_cfg = '0;
    logic                 signed_cfg = 1'b0;
    logic                 start_i = 1'b0;
    logic                 adc_valid_i = 1'b0;
    logic [NC*AB-1:0]     adc_out_i = '0;
    logic                 acc_valid_o;
    logic                 acc_ready_i = 1'b0;
    logic [NC*ACCB-1:0]   acc_data_o;
    logic                 busy_o;
    logic                 sat_o;
    logic                 err_o;

    int total = 0;
    int bad   = 0;

    adc_shift_accumulator #(
        .numCols(NC), .numAdcBits(AB), .numCfgBits(CB), .accBits(ACCB)
    ) dut (
        .clk(clk), .rst(rst), .n_input_bits_cfg(n_input_bits_cfg), .signed_cfg(signed_cfg),
        .start_i(start_i), .adc_valid_i(adc_valid_i), .adc_out_i(adc_out_i),
        .acc_valid_o(acc_valid_o), .acc_ready_i(acc_ready_i), .acc_data_o(acc_data_o),
        .busy_o(busy_o), .sat_o(sat_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int col(input int c);
        logic signed [ACCB-1:0] v;
        v = acc_data_o[c*ACCB +: ACCB];
        return int'(v);
    endfunction

    // Reference model: a MAC is "running" from an accepted start until its result is taken.
    bit m_running = 0, m_done = 0, m_sg = 0, m_sat = 0, m_err = 0;
    int m_n = 0, m_seen = 0;
    int m_acc [NC];

    task automatic model_begin();
        m_running = 1; m_done = 0; m_seen = 0; m_sat = 0; m_err = 0;
        m_n  = (n_input_bits_cfg == 0) ? 1 : int'(n_input_bits_cfg);
        m_sg = signed_cfg;
        for (int c = 0; c < NC; c++) m_acc[c] = 0;
    endtask

    task automatic model_plane();
        int s, w, v;
        for (int c = 0; c < NC; c++) begin
            s = int'(adc_out_i[c*AB +: AB]) - 8;
            w = (m_sg && m_seen == 0) ? -1 : 1;
            v = 2 * m_acc[c] + w * s;
            if (v > HI) begin v = HI; m_sat = 1; end
            if (v < LO) begin v = LO; m_sat = 1; end
            m_acc[c] = v;
        end
        m_seen++;
        if (m_seen == m_n) m_done = 1;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_running = 0; m_done = 0; m_sat = 0; m_err = 0; m_seen = 0;
            for (int c = 0; c < NC; c++) m_acc[c] = 0;
        end else if (!m_running) begin
            if (start_i) model_begin();
            else if (adc_valid_i) m_err = 1;
        end else if (!m_done) begin
            if (start_i) model_begin();
            else if (adc_valid_i) model_plane();
        end else begin
            if (acc_ready_i && start_i) model_begin();
            else begin
                if (adc_valid_i) m_err = 1;
                if (acc_ready_i) begin m_running = 0; m_done = 0; end
            end
        end
    end

    always @(negedge clk) begin
        check("model_valid", acc_valid_o, m_done);
        check("model_busy", busy_o, m_running);
        check("model_sat", sat_o, m_sat);
        check("model_err", err_o, m_err);
        if (m_done) begin
            for (int c = 0; c < NC; c++) check("model_data", col(c), m_acc[c]);
        end
    end

    // Stimulus tasks start and end at a falling edge.
    task automatic do_start(input bit sg, input int n);
        start_i = 1; signed_cfg = sg; n_input_bits_cfg = CB'(n); adc_valid_i = 0;
        @(negedge clk);
        start_i = 0;
        signed_cfg = 1'($urandom_range(0, 1));
        n_input_bits_cfg = CB'($urandom_range(0, 255));
    endtask

    task automatic plane(input int c0, input int c1);
        adc_valid_i = 1;
        adc_out_i = {AB'(c1), AB'(c0)};
        @(negedge clk);
        adc_valid_i = 0;
    endtask

    task automatic release_result();
        acc_ready_i = 1;
        @(negedge clk);
        acc_ready_i = 0;
        check("release_busy", busy_o, 0);
    endtask

    task automatic expect2(input string name, input int e0, input int e1);
        check({name, "_valid"}, acc_valid_o, 1);
        check({name, "_c0"}, col(0), e0);
        check({name, "_c1"}, col(1), e1);
    endtask

    initial begin
        int k, d;
        bit sg;
        #1 rst = 1;
        #2;
        check("rst_valid", acc_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_sat", sat_o, 0);
        check("rst_err", err_o, 0);
        check("rst_data", acc_data_o, 0);
        @(negedge clk);
        rst = 0;

        plane(5, 5);
        check("idle_drop_err", err_o, 1);

        do_start(0, 3);
        plane(12, 12); plane(8, 9); plane(4, 8);
        expect2("unsigned", 12, 18);
        check("unsigned_sat", sat_o, 0);
        check("unsigned_err", err_o, 0);
        release_result();

        do_start(1, 3);
        plane(12, 12); plane(8, 9); plane(4, 8);
        expect2("signed", -20, -14);
        release_result();

        do_start(1, 1);
        plane(15, 15);
        expect2("signed_n1", -7, -7);
        release_result();

        do_start(0, 0);
        plane(10, 6);
        expect2("n0_as_1", 2, -2);
        release_result();

        do_start(0, 8);
        repeat (8) plane(15, 15);
        expect2("sat_pos", 127, 127);
        check("sat_pos_flag", sat_o, 1);
        release_result();

        do_start(0, 8);
        repeat (8) plane(0, 0);
        expect2("sat_neg", -128, -128);
        check("sat_neg_flag", sat_o, 1);
        release_result();

        do_start(0, 2);
        plane(9, 10); plane(9, 10);
        expect2("bp_first", 3, 6);
        for (int i = 0; i < 5; i++) begin
            adc_valid_i = 1;
            adc_out_i = NC*AB'($urandom);
            @(negedge clk);
            expect2("bp_hold", 3, 6);
        end
        adc_valid_i = 0;
        check("bp_err", err_o, 1);
        release_result();

        do_start(0, 4);
        plane(3, 14); plane(7, 0);
        do_start(0, 4);
        repeat (4) plane(9, 9);
        expect2("restart", 15, 15);

        start_i = 1; acc_ready_i = 1; n_input_bits_cfg = 1; signed_cfg = 0;
        @(negedge clk);
        start_i = 0; acc_ready_i = 0;
        check("hs_start_busy", busy_o, 1);
        check("hs_start_valid", acc_valid_o, 0);
        plane(15, 0);
        expect2("hs_start", 7, -8);
        release_result();

        do_start(0, 3);
        plane(12, 12);
        #2 rst = 1;
        #1;
        check("arst_valid", acc_valid_o, 0);
        check("arst_busy", busy_o, 0);
        check("arst_data", acc_data_o, 0);
        check("arst_sat_err", {sat_o, err_o}, 0);
        @(negedge clk);
        rst = 0;
        do_start(0, 3);
        plane(12, 12); plane(8, 9); plane(4, 8);
        expect2("after_rst", 12, 18);
        release_result();

        for (int it = 0; it < 60; it++) begin
            sg = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) plane($urandom_range(0, 15), $urandom_range(0, 15));
            do_start(sg, $urandom_range(0, 6));
            k = 0;
            while (!acc_valid_o && k < 200) begin
                d = $urandom_range(0, 19);
                if (d == 0) do_start(sg, $urandom_range(1, 6));
                else if (d < 5) @(negedge clk);
                else plane($urandom_range(0, 15), $urandom_range(0, 15));
                k++;
            end
            check("rand_timeout", k < 200, 1);
            repeat ($urandom_range(0, 3)) begin
                adc_valid_i = 1'($urandom_range(0, 1));
                adc_out_i = NC*AB'($urandom);
                @(negedge clk);
            end
            adc_valid_i = 1'($urandom_range(0, 1));
            acc_ready_i = 1;
            start_i = ($urandom_range(0, 3) == 0);
            n_input_bits_cfg = CB'($urandom_range(1, 4));
            @(negedge clk);
            adc_valid_i = 0; acc_ready_i = 0; start_i = 0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
